dist_ram_sdp_be: RTL and testbench

Parametrised simple-dual-port distributed RAM with one write port and one read port on a single clock. Adds per-byte write enables, a selectable read latency, defined read-during-write collision behaviour and a hardware clear engine that zeroes the array after reset or on request. It is the general-purpose LUT-RAM buffer for datapath blocks that need independent read and write addresses and a known memory state.

---
 rtl/dist_ram_sdp_be.sv | 170 +++++++++++++++++
 tb/tb_dist_ram_sdp_be.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_ram_sdp_be.sv
// dist_ram_sdp_be: simple-dual-port LUT RAM, single clock.
// One write port with per-byte enables and one read port with 1- or 2-cycle
// latency. A clear engine zeroes every word after reset or on clr_req;
// both ports are ignored while it runs.
module dist_ram_sdp_be #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid
);

    localparam int NBYTES = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_next;

    (* ram_style = "distributed" *)
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_in_range;
    logic                rd_in_range;
    logic                wr_accept;
    logic                rd_accept;
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   s1_data;
    logic                s1_valid;

    // Clear-engine state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next-state logic: sweep every address once, then idle until clr_req.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        busy         = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_accept   = wr_en & ~busy & wr_in_range;
    assign rd_accept   = rd_en & ~busy;
    assign wr_old      = wr_in_range ? mem[wr_addr] : '0;

    // Byte-merge the write data into the currently stored word.
    always_comb begin
        wr_merged = wr_old;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Read word selection: out-of-range reads return zero; a same-address
    // collision forwards the merged word when write-first is selected.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if ((WRITE_FIRST != 0) && wr_accept && (wr_addr == rd_addr)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    // Array update: clear sweep has priority; contents are left alone in reset.
    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            mem[clr_cnt] <= '0;
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // First read stage; advances even while busy so an in-flight read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            // Extra output register stage for the two-cycle read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_data  = s2_data;
            assign rd_valid = s2_valid;
        end else begin : g_lat1
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_dist_ram_sdp_be.sv
// Directed self-checking bench for dist_ram_sdp_be.
// dut_a: defaults (RD_LAT=1, write-first); dut_b: RD_LAT=2, read-first,
// sharing dut_a's stimulus; dut_c: DEPTH=6 for out-of-range addressing.
module tb_dist_ram_sdp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic        a_busy, b_busy, c_busy;
    logic [31:0] a_rd_data, b_rd_data, c_rd_data;
    logic        a_rd_valid, b_rd_valid, c_rd_valid;

    logic        c_wr_en = 1'b0;
    logic [2:0]  c_wr_addr = '0;
    logic [31:0] c_wr_data = '0;
    logic        c_rd_en = 1'b0;
    logic [2:0]  c_rd_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int c;

    always #5 clk = ~clk;

    dist_ram_sdp_be #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .WRITE_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
    );

    dist_ram_sdp_be #(.DATA_W(32), .DEPTH(256), .RD_LAT(2), .WRITE_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(b_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    dist_ram_sdp_be #(.DATA_W(32), .DEPTH(6), .RD_LAT(1), .WRITE_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .clr_req(1'b0), .busy(c_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_be(4'hF), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (a_busy && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [3:0] be, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_be = be; wr_data = data;
        tick();
        wr_en = 1'b0; wr_be = '0;
    endtask

    // Single read: dut_a result one edge later, dut_b one edge after that.
    task automatic do_read(input string tag, input logic [7:0] addr,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
        rd_en = 1'b1; rd_addr = addr;
        tick();
        rd_en = 1'b0;
        check({tag, "_a_valid"}, 32'(a_rd_valid), 32'd1);
        check({tag, "_a_data"}, a_rd_data, exp_a);
        check({tag, "_b_early"}, 32'(b_rd_valid), 32'd0);
        tick();
        check({tag, "_a_valid_drop"}, 32'(a_rd_valid), 32'd0);
        check({tag, "_b_valid"}, 32'(b_rd_valid), 32'd1);
        check({tag, "_b_data"}, b_rd_data, exp_b);
    endtask

    task automatic c_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        c_rd_en = 1'b1; c_rd_addr = addr;
        tick();
        c_rd_en = 1'b0;
        check({tag, "_valid"}, 32'(c_rd_valid), 32'd1);
        check({tag, "_data"}, c_rd_data, exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_a_busy", 32'(a_busy), 32'd1);
        check("rst_b_busy", 32'(b_busy), 32'd1);
        check("rst_c_busy", 32'(c_busy), 32'd1);
        check("rst_a_data", a_rd_data, 32'h0);
        check("rst_a_valid", 32'(a_rd_valid), 32'd0);
        check("rst_b_data", b_rd_data, 32'h0);
        check("rst_b_valid", 32'(b_rd_valid), 32'd0);
        rst = 1'b0;
        wait_idle(n);
        check("init_clear_cycles", 32'(n), 32'd256);
        check("init_b_busy", 32'(b_busy), 32'd0);
        check("init_c_busy", 32'(c_busy), 32'd0);

        // Post-clear reads
        do_read("rd0", 8'd0, 32'h0, 32'h0);
        do_read("rd128", 8'd128, 32'h0, 32'h0);
        do_read("rd255", 8'd255, 32'h0, 32'h0);

        // Byte enables
        wr(8'd5, 4'b1111, 32'hDEADBEEF);
        wr(8'd5, 4'b0010, 32'h0000AA00);
        do_read("be_merge", 8'd5, 32'hDEADAAEF, 32'hDEADAAEF);
        wr(8'd5, 4'b0000, 32'hFFFFFFFF);
        do_read("be_none", 8'd5, 32'hDEADAAEF, 32'hDEADAAEF);

        // Same-cycle collision, full word
        wr(8'd9, 4'b1111, 32'hCAFEF00D);
        wr_en = 1'b1; wr_addr = 8'd9; wr_be = 4'b1111; wr_data = 32'h12345678;
        rd_en = 1'b1; rd_addr = 8'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
        check("coll_a_valid", 32'(a_rd_valid), 32'd1);
        check("coll_a_data", a_rd_data, 32'h12345678);
        tick();
        check("coll_b_valid", 32'(b_rd_valid), 32'd1);
        check("coll_b_data", b_rd_data, 32'hCAFEF00D);
        do_read("coll_after", 8'd9, 32'h12345678, 32'h12345678);

        // Same-cycle collision, partial bytes
        wr_en = 1'b1; wr_addr = 8'd9; wr_be = 4'b0001; wr_data = 32'h000000AA;
        rd_en = 1'b1; rd_addr = 8'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
        check("pcoll_a_data", a_rd_data, 32'h123456AA);
        tick();
        check("pcoll_b_data", b_rd_data, 32'h12345678);

        // Write then read next cycle returns new data at both policies
        wr(8'd10, 4'b1111, 32'h0BADC0DE);
        do_read("raw_next", 8'd10, 32'h0BADC0DE, 32'h0BADC0DE);

        // Fill with address values
        for (int i = 0; i < 256; i++) begin
            wr(8'(i), 4'b1111, 32'(i));
        end

        // Back-to-back reads 0..15
        for (int i = 0; i < 18; i++) begin
            rd_en = (i < 16); rd_addr = 8'(i);
            tick();
            if (i < 16) begin
                check("b2b_a_valid", 32'(a_rd_valid), 32'd1);
                check("b2b_a_data", a_rd_data, 32'(i));
            end else begin
                check("b2b_a_idle", 32'(a_rd_valid), 32'd0);
            end
            if (i >= 1 && i < 17) begin
                check("b2b_b_valid", 32'(b_rd_valid), 32'd1);
                check("b2b_b_data", b_rd_data, 32'(i - 1));
            end else begin
                check("b2b_b_idle", 32'(b_rd_valid), 32'd0);
            end
        end
        rd_en = 1'b0;

        // clr_req with a read accepted in the same (last idle) cycle
        rd_en = 1'b1; rd_addr = 8'd20; clr_req = 1'b1;
        tick();
        c = 1;
        clr_req = 1'b0;
        check("clr_busy", 32'(a_busy), 32'd1);
        check("clr_inflight_a_valid", 32'(a_rd_valid), 32'd1);
        check("clr_inflight_a_data", a_rd_data, 32'd20);
        wr_en = 1'b1; wr_addr = 8'd3; wr_be = 4'b1111; wr_data = 32'hFFFFFFFF;
        rd_addr = 8'd3;
        tick();
        c = 2;
        check("clr_inflight_b_valid", 32'(b_rd_valid), 32'd1);
        check("clr_inflight_b_data", b_rd_data, 32'd20);
        check("clr_busy_a_valid", 32'(a_rd_valid), 32'd0);
        while (a_busy && c < 400) begin
            clr_req = (c == 100);
            tick();
            c++;
            check("busy_a_valid", 32'(a_rd_valid), 32'd0);
            check("busy_b_valid", 32'(b_rd_valid), 32'd0);
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; wr_be = '0;
        check("clr_cycles", 32'(c), 32'd257);
        check("hold_a_data", a_rd_data, 32'd20);
        check("hold_b_data", b_rd_data, 32'd20);

        // Whole array zero after clear
        for (int i = 0; i < 256; i++) begin
            rd_en = 1'b1; rd_addr = 8'(i);
            tick();
            check("cleared_a_data", a_rd_data, 32'h0);
        end
        rd_en = 1'b0;
        tick();
        check("cleared_b_last", b_rd_data, 32'h0);

        // Reset in the middle of a clear
        wr(8'd7, 4'b1111, 32'hA5A5A5A5);
        do_read("pre_rst", 8'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(a_busy), 32'd1);
        check("mid_rst_a_data", a_rd_data, 32'h0);
        check("mid_rst_b_data", b_rd_data, 32'h0);
        tick();
        check("mid_rst_a_valid", 32'(a_rd_valid), 32'd0);
        check("mid_rst_b_valid", 32'(b_rd_valid), 32'd0);
        rst = 1'b0;
        wait_idle(n);
        check("restart_clear_cycles", 32'(n), 32'd256);
        do_read("post_rst", 8'd7, 32'h0, 32'h0);

        // DEPTH=6: out-of-range addresses
        c_wr_en = 1'b1; c_wr_addr = 3'd5; c_wr_data = 32'h55555555;
        tick();
        c_wr_addr = 3'd6; c_wr_data = 32'h66666666;
        tick();
        c_wr_en = 1'b0;
        c_read("c_in5", 3'd5, 32'h55555555);
        c_read("c_oor6", 3'd6, 32'h0);
        c_read("c_oor7", 3'd7, 32'h0);
        c_wr_en = 1'b1; c_wr_addr = 3'd6; c_wr_data = 32'h77777777;
        c_read("c_oor_coll", 3'd6, 32'h0);
        c_wr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
